// File: rtl/bpred_resolve_queue_pkg.sv
// Shared definitions for the branch-prediction resolve queue.
// These are the entry layout, the default sizes and the FSM state encoding.
package bpred_resolve_queue_pkg;

  localparam int unsigned PC_W          = 32;
  localparam int unsigned GHR_W         = 6;
  localparam int unsigned BIM_W         = 12;
  localparam int unsigned BTB_W         = 30;
  localparam int unsigned DEPTH_DEF     = 8;
  localparam int unsigned FLUSH_CYC_DEF = 2;

  // Entry packing offsets, LSB first: ghr | bimodal | p_target | p_dir | pc4
  localparam int unsigned GHR_LSB  = 0;
  localparam int unsigned BIM_LSB  = GHR_LSB + GHR_W;
  localparam int unsigned PTGT_LSB = BIM_LSB + BIM_W;
  localparam int unsigned PDIR_LSB = PTGT_LSB + PC_W;
  localparam int unsigned PC4_LSB  = PDIR_LSB + 1;
  localparam int unsigned ENTRY_W  = PC4_LSB + PC_W;

  typedef struct packed {
    logic [PC_W-1:0]  pc4;
    logic             p_dir;
    logic [PC_W-1:0]  p_target;
    logic [BIM_W-1:0] bimodal;
    logic [GHR_W-1:0] ghr;
  } rq_entry_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } rq_state_t;

endpackage

// File: rtl/bpred_rq_store.sv
// Entry storage for the resolve queue.
// It has one synchronous write port and one asynchronous read port at the head.
module bpred_rq_store
  import bpred_resolve_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  rq_entry_t     i_wdata,
  input  logic [AW-1:0] i_raddr,
  output rq_entry_t     o_rdata
);

  // Contents need no reset: the pointers mark which slots are valid
  rq_entry_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bpred_resolve_queue.sv
// In-order tracker for branch predictions awaiting resolution in execute.
// It drives predictor updates, and on a mispredict it flushes the wrong-path entries and redirects fetch.
module bpred_resolve_queue
  import bpred_resolve_queue_pkg::*;
#(
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned FLUSH_CYC = FLUSH_CYC_DEF,
  localparam int unsigned AW       = $clog2(DEPTH),
  localparam int unsigned PW       = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fq_push,
  input  logic [31:0]      fq_pc4,
  input  logic             fq_p_dir,
  input  logic [31:0]      fq_p_target,
  input  logic [BIM_W-1:0] fq_bimodal,
  input  logic [GHR_W-1:0] fq_ghr,
  output logic             fq_full,
  input  logic             ex_resolve,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  input  logic             ex_stall,
  output logic             execute_bpredictor_update,
  output logic [31:0]      execute_bpredictor_PC4,
  output logic [31:0]      execute_bpredictor_target,
  output logic             execute_bpredictor_dir,
  output logic             execute_bpredictor_miss,
  output logic [BIM_W-1:0] execute_bpredictor_bimodal,
  output logic [BTB_W-1:0] up_btb_data,
  output logic [GHR_W-1:0] up_carry_data,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [PW-1:0]    occupancy,
  output logic             err_underflow,
  output logic             err_overflow
);

  localparam int unsigned CW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  logic [PW-1:0] r_wr, r_rd, w_wr_nxt, w_rd_nxt, w_occ_nxt;
  rq_state_t     r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  rq_entry_t     w_head, w_new;
  logic          w_empty, w_full, w_full_nxt, w_run;
  logic          w_pop, w_miss, w_flush, w_push, w_ovf, w_unf;

  bpred_rq_store #(.DEPTH(DEPTH)) u_store (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr[AW-1:0]),
    .i_wdata (w_new),
    .i_raddr (r_rd[AW-1:0]),
    .o_rdata (w_head)
  );

  always_comb begin
    w_new          = '0;
    w_new.pc4      = fq_pc4;
    w_new.p_dir    = fq_p_dir;
    w_new.p_target = fq_p_target;
    w_new.bimodal  = fq_bimodal;
    w_new.ghr      = fq_ghr;
  end

  // Pointers carry one extra wrap bit so full and empty can be told apart
  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[PW-1] != r_rd[PW-1]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_run   = (r_state == ST_RUN);

  assign w_pop   = ex_resolve & ~ex_stall & ~w_empty;
  assign w_miss  = (w_head.p_dir != ex_taken) |
                   (ex_taken & w_head.p_dir & (w_head.p_target != ex_target));
  assign w_flush = w_pop & w_miss;
  assign w_push  = fq_push & w_run & ~w_flush & (~w_full | w_pop);
  assign w_ovf   = fq_push & w_run & w_full & ~w_pop;
  assign w_unf   = ex_resolve & ~ex_stall & w_empty;

  // A mispredict discards every younger entry, so the write pointer snaps to the new head
  assign w_rd_nxt   = r_rd + PW'(w_pop);
  assign w_wr_nxt   = w_flush ? w_rd_nxt : (r_wr + PW'(w_push));
  assign w_occ_nxt  = w_wr_nxt - w_rd_nxt;
  assign w_full_nxt = (w_wr_nxt[PW-1] != w_rd_nxt[PW-1]) &&
                      (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wr    <= w_wr_nxt;
      r_rd    <= w_rd_nxt;
    end
  end

  // The FLUSH state lasts FLUSH_CYC cycles after the mispredict cycle
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_flush) begin
          w_state_nxt = ST_FLUSH;
          w_cnt_nxt   = CW'(FLUSH_CYC - 1);
        end
      end
      ST_FLUSH: begin
        if (r_cnt == '0) w_state_nxt = ST_RUN;
        else             w_cnt_nxt   = r_cnt - CW'(1);
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fq_full                    <= 1'b0;
      execute_bpredictor_update  <= 1'b0;
      execute_bpredictor_PC4     <= '0;
      execute_bpredictor_target  <= '0;
      execute_bpredictor_dir     <= 1'b0;
      execute_bpredictor_miss    <= 1'b0;
      execute_bpredictor_bimodal <= '0;
      up_btb_data                <= '0;
      up_carry_data              <= '0;
      redirect_valid             <= 1'b0;
      redirect_pc                <= '0;
      occupancy                  <= '0;
      err_underflow              <= 1'b0;
      err_overflow               <= 1'b0;
    end else begin
      fq_full                   <= w_full_nxt;
      occupancy                 <= w_occ_nxt;
      execute_bpredictor_update <= w_pop;
      redirect_valid            <= w_flush;
      err_underflow             <= err_underflow | w_unf;
      err_overflow              <= err_overflow | w_ovf;
      if (w_pop) begin
        execute_bpredictor_PC4     <= w_head.pc4;
        execute_bpredictor_target  <= ex_target;
        execute_bpredictor_dir     <= ex_taken;
        execute_bpredictor_miss    <= w_miss;
        execute_bpredictor_bimodal <= w_head.bimodal;
        up_btb_data                <= ex_target[31:2];
        up_carry_data              <= w_head.ghr;
        redirect_pc                <= ex_taken ? ex_target : w_head.pc4;
      end
    end
  end

endmodule
